// File: rtl/ahb_gpio_master_seq_pkg.sv
// Shared types and constants for the GPIO AHB-Lite sequencer.
package gpio_seq_pkg;

    typedef enum logic [1:0] {
        RD_DATA = 2'b00,
        WR_DATA = 2'b01,
        WR_DIR  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // The transfer currently owned by the FSM; polls reuse the RD_DATA path.
    typedef struct packed {
        op_e         op;
        logic [15:0] wdata;
        logic        is_poll;
    } xfer_t;

    // Direction writes go to the direction register, everything else to data.
    function automatic logic [31:0] op_addr(input op_e op, input logic [31:0] base,
                                            input logic [31:0] dir);
        return (op == WR_DIR) ? dir : base;
    endfunction

endpackage

// File: rtl/ahb_gpio_master_seq_if.sv
// AHB-Lite signals between the sequencer (master) and the GPIO slave.
interface ahb_gpio_master_seq_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        PARITYERR;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        input  HREADY, HRDATA, PARITYERR
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        output HREADY, HRDATA, PARITYERR
    );
endinterface

// File: rtl/ahb_gpio_master_seq_poll_timer.sv
// Free-running poll interval counter with a single-entry pending flag.
module gpio_poll_timer #(
    parameter int POLL_DIV = 1000,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic poll_en,
    input  logic poll_start,
    output logic poll_pend
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             tick;

    // Count while enabled; a wrap raises pend, a launched poll drops it.
    // A wrap that lands while pend is still high simply leaves it high.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        tick   = 1'b0;
        if (!poll_en) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (poll_start) pend_d = 1'b0;
            if (tick)       pend_d = 1'b1;
        end
    end

    // Counter and pending flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign poll_pend = pend_q;
endmodule

// File: rtl/ahb_gpio_master_seq.sv
// Single-master AHB-Lite sequencer owning the GPIO bus port: host commands
// become one non-pipelined transfer each; idle time is used for periodic polls.
module ahb_gpio_master_seq
    import gpio_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h5300_0000,
    parameter logic [31:0] DIR_ADDR  = 32'h5300_0004,
    parameter int          POLL_DIV  = 1000,
    parameter int          CNT_W     = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [15:0]           cmd_wdata,
    output logic                  rsp_valid,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_err,
    input  logic                  poll_en,
    output logic [15:0]           poll_data,
    output logic                  change_irq,
    output logic [15:0]           dir_shadow,
    ahb_gpio_master_seq_if.master ahb
);
    state_e      state_q, state_d;
    xfer_t       cur_q, cur_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        irq_q, irq_d;
    logic [15:0] poll_data_q, poll_data_d;
    logic [15:0] dir_shadow_q, dir_shadow_d;
    logic        first_poll_q, first_poll_d;
    logic        poll_start;
    logic        poll_pend;
    logic        unused_hrdata_hi;

    assign unused_hrdata_hi = ^ahb.HRDATA[31:16];

    gpio_poll_timer #(
        .POLL_DIV (POLL_DIV),
        .CNT_W    (CNT_W)
    ) u_poll_timer (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .poll_en    (poll_en),
        .poll_start (poll_start),
        .poll_pend  (poll_pend)
    );

    // Next-state: host commands beat pending polls; data captured on the
    // HREADY-high edge of the data phase.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        irq_d        = irq_q;
        poll_data_d  = poll_data_q;
        dir_shadow_d = dir_shadow_q;
        first_poll_d = first_poll_q;
        poll_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cur_d.op      = op_e'(cmd_op);
                    cur_d.wdata   = cmd_wdata;
                    cur_d.is_poll = 1'b0;
                    rdata_d       = '0;
                    irq_d         = 1'b0;
                    if (op_e'(cmd_op) == OP_RSVD) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ADDR;
                    end
                end else if (poll_pend) begin
                    cur_d.op      = RD_DATA;
                    cur_d.wdata   = '0;
                    cur_d.is_poll = 1'b1;
                    rdata_d       = '0;
                    err_d         = 1'b0;
                    irq_d         = 1'b0;
                    poll_start    = 1'b1;
                    state_d       = ADDR;
                end
            end
            ADDR: begin
                if (ahb.HREADY) state_d = DATA;
            end
            DATA: begin
                if (ahb.HREADY) begin
                    state_d = RESP;
                    if (cur_q.is_poll) begin
                        // Parity errors on polls are deliberately dropped.
                        poll_data_d  = ahb.HRDATA[15:0];
                        irq_d        = !first_poll_q && (ahb.HRDATA[15:0] != poll_data_q);
                        first_poll_d = 1'b0;
                    end else begin
                        case (cur_q.op)
                            RD_DATA: begin
                                rdata_d = ahb.HRDATA[15:0];
                                err_d   = ahb.PARITYERR;
                            end
                            WR_DIR:  dir_shadow_d = cur_q.wdata;
                            default: ;
                        endcase
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            irq_q        <= 1'b0;
            poll_data_q  <= '0;
            dir_shadow_q <= '0;
            first_poll_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            irq_q        <= irq_d;
            poll_data_q  <= poll_data_d;
            dir_shadow_q <= dir_shadow_d;
            first_poll_q <= first_poll_d;
        end
    end

    // Bus drive decoded from state so reset forces the bus idle immediately.
    always_comb begin
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = HTRANS_IDLE;
        ahb.HADDR  = '0;
        ahb.HWRITE = 1'b0;
        ahb.HWDATA = '0;
        if (state_q == ADDR) begin
            ahb.HSEL   = 1'b1;
            ahb.HTRANS = HTRANS_NONSEQ;
            ahb.HADDR  = op_addr(cur_q.op, BASE_ADDR, DIR_ADDR);
            ahb.HWRITE = (cur_q.op != RD_DATA);
        end
        if (state_q == DATA && cur_q.op != RD_DATA)
            ahb.HWDATA = {16'h0000, cur_q.wdata};
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP) && !cur_q.is_poll;
    assign rsp_rdata  = rsp_valid ? rdata_q : 16'h0000;
    assign rsp_err    = rsp_valid && err_q;
    assign change_irq = (state_q == RESP) && cur_q.is_poll && irq_q;
    assign poll_data  = poll_data_q;
    assign dir_shadow = dir_shadow_q;
endmodule

// File: tb/tb_ahb_gpio_master_seq.sv
// Self-checking bench: randomized host commands against a transaction-level
// model, plus directed poll, priority and reset scenarios.
module tb_ahb_gpio_master_seq;
    import gpio_seq_pkg::*;

    localparam int          PDIV = 8;
    localparam logic [31:0] BASE = 32'h5300_0000;
    localparam logic [31:0] DIRA = 32'h5300_0004;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_wdata = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        poll_en = 1'b0;
    logic [15:0] poll_data;
    logic        change_irq;
    logic [15:0] dir_shadow;

    int errors = 0;
    int checks = 0;

    ahb_gpio_master_seq_if bus();

    ahb_gpio_master_seq #(
        .BASE_ADDR (BASE), .DIR_ADDR (DIRA), .POLL_DIV (PDIV), .CNT_W (16)
    ) dut (
        .HCLK (HCLK), .HRESETn (HRESETn),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op), .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .poll_en (poll_en), .poll_data (poll_data), .change_irq (change_irq),
        .dir_shadow (dir_shadow), .ahb (bus)
    );

    always #5 HCLK = ~HCLK;

    // Behavioural GPIO slave: configurable wait states, logs each finished transfer.
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } xfer_rec_t;

    xfer_rec_t   xlog[$];
    int          wait_cfg = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic        perr_cfg = 1'b0;
    logic        sl_dphase;
    int          sl_wait;
    logic [31:0] sl_addr;
    logic        sl_wr;
    int          aphase_cnt = 0;

    assign bus.HREADY    = !(sl_dphase && sl_wait != 0);
    assign bus.HRDATA    = rdata_cfg;
    assign bus.PARITYERR = sl_dphase && perr_cfg;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sl_dphase <= 1'b0;
            sl_wait   <= 0;
        end else begin
            if (sl_dphase && bus.HREADY) begin
                xlog.push_back('{sl_addr, sl_wr, bus.HWDATA});
                sl_dphase <= 1'b0;
            end else if (sl_dphase) begin
                sl_wait <= sl_wait - 1;
            end
            if (bus.HSEL && bus.HTRANS == HTRANS_NONSEQ && bus.HREADY) begin
                sl_dphase  <= 1'b1;
                sl_wait    <= wait_cfg;
                sl_addr    <= bus.HADDR;
                sl_wr      <= bus.HWRITE;
                aphase_cnt <= aphase_cnt + 1;
            end
        end
    end

    // Pulse counters, sampled at the end of each cycle.
    int rsp_cnt = 0;
    int irq_cnt = 0;
    always @(posedge HCLK) begin
        if (rsp_valid)  rsp_cnt <= rsp_cnt + 1;
        if (change_irq) irq_cnt <= irq_cnt + 1;
    end

    // Reference model: response latency from accept.
    function automatic int exp_lat(input logic [1:0] op, input int waits);
        return (op == 2'b11) ? 1 : 3 + waits;
    endfunction

    // Drive one command (called at a negedge); returns latency, response, pulse width flag.
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] wd, input int waits,
                          input logic [31:0] rd, input logic perr, output int lat,
                          output logic [15:0] r_rdata, output logic r_err, output logic one_cyc);
        int budget;
        wait_cfg  = waits;
        rdata_cfg = rd;
        perr_cfg  = perr;
        budget    = 0;
        while (!cmd_ready && budget < 50) begin
            @(negedge HCLK);
            budget++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        @(posedge HCLK);
        @(negedge HCLK);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge HCLK);
            lat++;
        end
        r_rdata = rsp_rdata;
        r_err   = rsp_err;
        if (!rsp_valid) lat = -1;
        @(negedge HCLK);
        one_cyc = !rsp_valid;
    endtask

    task automatic test_reset();
        #1 HRESETn = 1'b0;
        #2;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if ({rsp_valid, rsp_err, change_irq} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {rsp_valid, rsp_err, change_irq}); end
        checks++; if ({rsp_rdata, poll_data, dir_shadow} !== 48'h0) begin errors++; $display("FAIL reset_data got %h want 0", {rsp_rdata, poll_data, dir_shadow}); end
        checks++; if ({bus.HSEL, bus.HTRANS, bus.HWRITE} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {bus.HSEL, bus.HTRANS, bus.HWRITE}); end
        checks++; if ({bus.HADDR, bus.HWDATA} !== 64'h0) begin errors++; $display("FAIL reset_addr_data got %h want 0", {bus.HADDR, bus.HWDATA}); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_write_seq();
        int lat; logic [15:0] rr; logic re, oc; int n;
        n = xlog.size();
        do_cmd(2'b10, 16'h0001, 0, 32'h0, 1'b0, lat, rr, re, oc);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_dir_latency got %0d want 3", lat); end
        checks++; if (oc !== 1'b1) begin errors++; $display("FAIL wr_dir_pulse_width got %b want 1", oc); end
        do_cmd(2'b01, 16'hA5A5, 0, 32'h0, 1'b0, lat, rr, re, oc);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_data_latency got %0d want 3", lat); end
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL wr_data_err got %b want 0", re); end
        checks++; if (dir_shadow !== 16'h0001) begin errors++; $display("FAIL dir_shadow got %h want 0001", dir_shadow); end
        checks++;
        if (xlog.size() != n + 2) begin
            errors++; $display("FAIL wr_xfer_count got %0d want %0d", xlog.size() - n, 2);
        end else begin
            checks++; if (xlog[n].addr !== DIRA || xlog[n].wr !== 1'b1 || xlog[n].wdata !== 32'h1) begin
                errors++; $display("FAIL wr_dir_xfer got %h/%b/%h want %h/1/00000001", xlog[n].addr, xlog[n].wr, xlog[n].wdata, DIRA); end
            checks++; if (xlog[n+1].addr !== BASE || xlog[n+1].wr !== 1'b1 || xlog[n+1].wdata !== 32'h0000A5A5) begin
                errors++; $display("FAIL wr_data_xfer got %h/%b/%h want %h/1/0000a5a5", xlog[n+1].addr, xlog[n+1].wr, xlog[n+1].wdata, BASE); end
        end
    endtask

    task automatic test_read_wait();
        int lat; logic [15:0] rr; logic re, oc;
        do_cmd(2'b00, 16'h0, 2, 32'h0000_1234, 1'b0, lat, rr, re, oc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rd_wait_latency got %0d want 5", lat); end
        checks++; if (rr !== 16'h1234) begin errors++; $display("FAIL rd_wait_rdata got %h want 1234", rr); end
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL rd_wait_err got %b want 0", re); end
    endtask

    task automatic test_parity_rsvd();
        int lat; logic [15:0] rr; logic re, oc; int a0, n;
        do_cmd(2'b00, 16'h0, 0, 32'h0000_5A5A, 1'b1, lat, rr, re, oc);
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL rd_parity_err got %b want 1", re); end
        checks++; if (rr !== 16'h5A5A) begin errors++; $display("FAIL rd_parity_rdata got %h want 5a5a", rr); end
        a0 = aphase_cnt; n = xlog.size();
        do_cmd(2'b11, 16'hFFFF, 0, 32'h0, 1'b0, lat, rr, re, oc);
        perr_cfg = 1'b0;
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL rsvd_err got %b want 1", re); end
        checks++; if (lat !== exp_lat(2'b11, 0)) begin errors++; $display("FAIL rsvd_latency got %0d want %0d", lat, exp_lat(2'b11, 0)); end
        checks++; if (aphase_cnt !== a0 || xlog.size() != n) begin errors++; $display("FAIL rsvd_no_bus got %0d transfers want 0", aphase_cnt - a0); end
    endtask

    task automatic test_poll_change();
        int irq0, n, budget; int lat; logic [15:0] rr; logic re, oc;
        logic [15:0] vals [3];
        vals[0] = 16'h0001; vals[1] = 16'h0003; vals[2] = 16'h0003;
        irq0 = irq_cnt;
        wait_cfg = 0; perr_cfg = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rdata_cfg = {16'hFFFF, vals[k]};
            n = xlog.size();
            if (k == 0) poll_en = 1'b1;
            budget = 0;
            while (xlog.size() == n && budget < 40) begin @(negedge HCLK); budget++; end
            if (k == 2) poll_en = 1'b0;
            repeat (2) @(negedge HCLK);
            checks++; if (xlog.size() == n) begin errors++; $display("FAIL poll_%0d_timeout got 0 polls want 1", k); end
            checks++; if (poll_data !== vals[k]) begin errors++; $display("FAIL poll_%0d_data got %h want %h", k, poll_data, vals[k]); end
            checks++; if (irq_cnt - irq0 !== (k == 0 ? 0 : 1)) begin
                errors++; $display("FAIL poll_%0d_irq got %0d want %0d", k, irq_cnt - irq0, (k == 0 ? 0 : 1)); end
        end
        perr_cfg = 1'b0;
        repeat (4) @(negedge HCLK);
        do_cmd(2'b00, 16'h0, 0, 32'h0000_BEEF, 1'b0, lat, rr, re, oc);
        checks++; if (rr !== 16'hBEEF) begin errors++; $display("FAIL host_rd_after_poll got %h want beef", rr); end
        checks++; if (poll_data !== 16'h0003) begin errors++; $display("FAIL host_rd_poll_data got %h want 0003", poll_data); end
    endtask

    task automatic test_cmd_vs_poll();
        int lat; logic [15:0] rr; logic re, oc; int n, a0, budget; logic [15:0] wd;
        wd = 16'($urandom);
        repeat (2) @(negedge HCLK);
        n = xlog.size(); a0 = aphase_cnt;
        rdata_cfg = 32'h0000_0007;
        poll_en = 1'b1;
        repeat (PDIV) @(posedge HCLK);
        @(negedge HCLK);
        do_cmd(2'b01, wd, 0, 32'h0000_0007, 1'b0, lat, rr, re, oc);
        budget = 0;
        while (aphase_cnt < a0 + 2 && budget < 20) begin @(negedge HCLK); budget++; end
        poll_en = 1'b0;
        repeat (12) @(negedge HCLK);
        checks++; if (lat !== 3) begin errors++; $display("FAIL prio_cmd_latency got %0d want 3", lat); end
        checks++; if (aphase_cnt - a0 !== 2) begin errors++; $display("FAIL prio_xfer_count got %0d want 2", aphase_cnt - a0); end
        checks++;
        if (xlog.size() < n + 2) begin
            errors++; $display("FAIL prio_log got %0d want 2", xlog.size() - n);
        end else if (xlog[n].wr !== 1'b1 || xlog[n].wdata !== {16'h0, wd} || xlog[n+1].wr !== 1'b0 || xlog[n+1].addr !== BASE) begin
            errors++; $display("FAIL prio_order got wr=%b,%b want 1,0", xlog[n].wr, xlog[n+1].wr);
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        r0 = rsp_cnt;
        wait_cfg = 5;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_wdata = 16'h0;
        @(posedge HCLK); @(negedge HCLK);
        cmd_valid = 1'b0;
        @(negedge HCLK);
        checks++; if (cmd_ready !== 1'b0 || bus.HREADY !== 1'b0) begin
            errors++; $display("FAIL rstmid_in_data got ready=%b hready=%b want 0,0", cmd_ready, bus.HREADY); end
        HRESETn = 1'b0;
        #1;
        checks++; if ({bus.HSEL, bus.HTRANS, cmd_ready} !== 4'b0001) begin
            errors++; $display("FAIL rstmid_async got %b want 0001", {bus.HSEL, bus.HTRANS, cmd_ready}); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        wait_cfg = 0;
        repeat (8) @(negedge HCLK);
        checks++; if (rsp_cnt !== r0) begin errors++; $display("FAIL rstmid_no_rsp got %0d want 0", rsp_cnt - r0); end
        checks++; if ({bus.HSEL, bus.HTRANS, cmd_ready} !== 4'b0001) begin
            errors++; $display("FAIL rstmid_after got %b want 0001", {bus.HSEL, bus.HTRANS, cmd_ready}); end
        checks++; if ({dir_shadow, poll_data} !== 32'h0) begin errors++; $display("FAIL rstmid_state got %h want 0", {dir_shadow, poll_data}); end
    endtask

    task automatic test_random();
        int lat, waits, n, el; logic [15:0] rr, wd, exp_rd, exp_dir; logic re, oc, perr, exp_err;
        logic [1:0] op; logic [31:0] rd;
        exp_dir = 16'h0;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3)); waits = $urandom_range(0, 3);
            wd = 16'($urandom); rd = $urandom; perr = 1'($urandom);
            n = xlog.size();
            do_cmd(op, wd, waits, rd, perr, lat, rr, re, oc);
            el      = exp_lat(op, waits);
            exp_rd  = (op == 2'b00) ? rd[15:0] : 16'h0;
            exp_err = (op == 2'b11) || (op == 2'b00 && perr);
            if (op == 2'b10) exp_dir = wd;
            checks++; if (lat !== el || oc !== 1'b1) begin errors++; $display("FAIL rnd%0d_latency got %0d/%b want %0d/1", i, lat, oc, el); end
            checks++; if (rr !== exp_rd || re !== exp_err) begin errors++; $display("FAIL rnd%0d_rsp got %h/%b want %h/%b", i, rr, re, exp_rd, exp_err); end
            checks++; if (dir_shadow !== exp_dir) begin errors++; $display("FAIL rnd%0d_dir got %h want %h", i, dir_shadow, exp_dir); end
            checks++;
            if (op == 2'b11) begin
                if (xlog.size() != n) begin errors++; $display("FAIL rnd%0d_rsvd_bus got %0d want 0", i, xlog.size() - n); end
            end else if (xlog.size() != n + 1) begin
                errors++; $display("FAIL rnd%0d_xfer_count got %0d want 1", i, xlog.size() - n);
            end else if (xlog[n].addr !== (op == 2'b10 ? DIRA : BASE) || xlog[n].wr !== (op != 2'b00) ||
                         (op != 2'b00 && xlog[n].wdata !== {16'h0, wd})) begin
                errors++; $display("FAIL rnd%0d_xfer got %h/%b/%h want op %0d wd %h", i, xlog[n].addr, xlog[n].wr, xlog[n].wdata, op, wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_seq();
        test_read_wait();
        test_parity_rsvd();
        test_poll_change();
        test_cmd_vs_poll();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
